// File: rtl/pipa_moding_emulator.sv
// pipa_moding_emulator
//   Synthesizable stand-in for the AGC bench's PIPA spoofing. It follows the
//   AGC moding clock (PIPASW) through a FRAME_LEN-slot frame. On each
//   interrogate pulse (PIPDAT) it drives the plus or the minus rail of every
//   axis. Which rail depends on whether the current slot falls below that
//   axis's plus-slot count P. It also keeps a signed net-pulse tally per axis.
//
// Ports
//   SIM_CLK, SIM_RST_n      clock / synchronous active-low reset
//   PIPASW, PIPDAT          AGC moding clock and interrogate pulse
//   EN                      emulator enable (0 gates all PIPA outputs low)
//   ACCEL_X/Y/Z [2:0]       signed moding offset per axis (-4 treated as -3)
//   FAIL_X/Y/Z              fault inject: both rails of the axis pulse together
//   CNT_CLR                 synchronous clear of the net tallies
//   PIPA{X,Y,Z}{p,m}        registered PIPA rail outputs
//   SLOT [2:0], FRAME_STB   current moding slot, one-cycle strobe on wrap to 0
//   NET_X/Y/Z [ACC_W-1:0]   two's-complement net delivered pulses per axis
module pipa_moding_emulator #(
  parameter int FRAME_LEN = 6,
  parameter int ACC_W     = 16
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST_n,
  input  logic             PIPASW,
  input  logic             PIPDAT,
  input  logic             EN,
  input  logic [2:0]       ACCEL_X,
  input  logic [2:0]       ACCEL_Y,
  input  logic [2:0]       ACCEL_Z,
  input  logic             FAIL_X,
  input  logic             FAIL_Y,
  input  logic             FAIL_Z,
  input  logic             CNT_CLR,
  output logic             PIPAXp,
  output logic             PIPAXm,
  output logic             PIPAYp,
  output logic             PIPAYm,
  output logic             PIPAZp,
  output logic             PIPAZm,
  output logic [2:0]       SLOT,
  output logic             FRAME_STB,
  output logic [ACC_W-1:0] NET_X,
  output logic [ACC_W-1:0] NET_Y,
  output logic [ACC_W-1:0] NET_Z
);

  localparam logic [2:0] LAST_SLOT = 3'(FRAME_LEN - 1);
  localparam logic [2:0] P_RESET   = 3'd3;

  logic             sw_q;
  logic [2:0]       slot;
  logic             frame_stb;
  logic             sw_edge;
  logic             wrap;
  logic [2:0]       slot_nxt;
  logic [2:0]       slot_eff;

  logic [2:0]       accel [3];
  logic [2:0]       p_cnt [3];
  logic [ACC_W-1:0] net   [3];
  logic [2:0]       fail;
  logic [2:0]       p_q, m_q;
  logic [2:0]       p_d, m_d;

  // Plus-slot count for a signed offset: 3 + clamp(a, -3, +3).
  function automatic logic [2:0] plus_count(input logic [2:0] a);
    logic [2:0] r;
    case (a)
      3'b000:  r = 3'd3;
      3'b001:  r = 3'd4;
      3'b010:  r = 3'd5;
      3'b011:  r = 3'd6;
      3'b100:  r = 3'd0;
      3'b101:  r = 3'd0;
      3'b110:  r = 3'd1;
      default: r = 3'd2;
    endcase
    return r;
  endfunction

  assign accel[0] = ACCEL_X;
  assign accel[1] = ACCEL_Y;
  assign accel[2] = ACCEL_Z;
  assign fail     = {FAIL_Z, FAIL_Y, FAIL_X};

  assign sw_edge  = PIPASW & ~sw_q;
  assign slot_nxt = (slot == LAST_SLOT) ? '0 : slot + 3'd1;
  assign wrap     = sw_edge & (slot == LAST_SLOT);
  // Rails follow the slot being entered on an edge cycle, so they never lag PIPASW.
  assign slot_eff = sw_edge ? slot_nxt : slot;

  always_comb begin
    p_d = '0;
    m_d = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      p_d[i] = EN & PIPDAT & ((slot_eff <  p_cnt[i]) | fail[i]);
      m_d[i] = EN & PIPDAT & ((slot_eff >= p_cnt[i]) | fail[i]);
    end
  end

  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST_n) begin
      sw_q      <= 1'b0;
      slot      <= '0;
      frame_stb <= 1'b0;
      p_q       <= '0;
      m_q       <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        p_cnt[i] <= P_RESET;
        net[i]   <= '0;
      end
    end else begin
      sw_q      <= PIPASW;
      frame_stb <= wrap;
      if (sw_edge)
        slot <= slot_nxt;
      p_q <= p_d;
      m_q <= m_d;
      for (int unsigned i = 0; i < 3; i++) begin
        // P changes only at a frame boundary (or while idle) so a frame is never split.
        if (wrap || !EN)
          p_cnt[i] <= plus_count(accel[i]);
        // Tally on the rising edge of the rail being registered this cycle.
        if (CNT_CLR)
          net[i] <= '0;
        else if (p_d[i] && !p_q[i] && !m_d[i])
          net[i] <= net[i] + ACC_W'(1);
        else if (m_d[i] && !m_q[i] && !p_d[i])
          net[i] <= net[i] - ACC_W'(1);
      end
    end
  end

  assign PIPAXp    = p_q[0];
  assign PIPAXm    = m_q[0];
  assign PIPAYp    = p_q[1];
  assign PIPAYm    = m_q[1];
  assign PIPAZp    = p_q[2];
  assign PIPAZm    = m_q[2];
  assign SLOT      = slot;
  assign FRAME_STB = frame_stb;
  assign NET_X     = net[0];
  assign NET_Y     = net[1];
  assign NET_Z     = net[2];

endmodule

// File: tb/tb_pipa_moding_emulator.sv
// tb_pipa_moding_emulator
//   Drives the emulator with directed scenarios followed by randomized traffic.
//   Every cycle it compares the DUT against a behavioural model. The model
//   counts PIPASW edges, derives the slot as the edge count modulo FRAME_LEN,
//   and picks the rail per axis from the current plus-slot count.
module tb_pipa_moding_emulator;

  localparam int FRAME_LEN = 6;
  localparam int ACC_W     = 16;

  logic             SIM_CLK = 1'b0;
  logic             SIM_RST_n;
  logic             PIPASW, PIPDAT, EN;
  logic [2:0]       ACCEL_X, ACCEL_Y, ACCEL_Z;
  logic             FAIL_X, FAIL_Y, FAIL_Z;
  logic             CNT_CLR;
  logic             PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm;
  logic [2:0]       SLOT;
  logic             FRAME_STB;
  logic [ACC_W-1:0] NET_X, NET_Y, NET_Z;

  pipa_moding_emulator #(.FRAME_LEN(FRAME_LEN), .ACC_W(ACC_W)) dut (
    .SIM_CLK(SIM_CLK), .SIM_RST_n(SIM_RST_n), .PIPASW(PIPASW), .PIPDAT(PIPDAT),
    .EN(EN), .ACCEL_X(ACCEL_X), .ACCEL_Y(ACCEL_Y), .ACCEL_Z(ACCEL_Z),
    .FAIL_X(FAIL_X), .FAIL_Y(FAIL_Y), .FAIL_Z(FAIL_Z), .CNT_CLR(CNT_CLR),
    .PIPAXp(PIPAXp), .PIPAXm(PIPAXm), .PIPAYp(PIPAYp), .PIPAYm(PIPAYm),
    .PIPAZp(PIPAZp), .PIPAZm(PIPAZm), .SLOT(SLOT), .FRAME_STB(FRAME_STB),
    .NET_X(NET_X), .NET_Y(NET_Y), .NET_Z(NET_Z)
  );

  always #5 SIM_CLK = ~SIM_CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  int         m_edges;
  bit         m_sw;
  int         m_P   [3];
  bit         m_p   [3];
  bit         m_m   [3];
  logic [15:0] m_net[3];
  bit         m_stb;

  // Observed-event counters for the directed frame checks
  int  stb_cnt, xp_rise, xm_rise;
  bit  prev_xp, prev_xm;

  function automatic int offset_of(input logic [2:0] a);
    int v;
    v = a[2] ? int'(a) - 8 : int'(a);
    if (v < -3) v = -3;
    return v;
  endfunction

  function automatic int m_slot();
    return m_edges % FRAME_LEN;
  endfunction

  task automatic model_reset();
    m_edges = 0;
    m_sw    = 0;
    m_stb   = 0;
    for (int a = 0; a < 3; a++) begin
      m_P[a] = 3; m_p[a] = 0; m_m[a] = 0; m_net[a] = '0;
    end
  endtask

  task automatic model_step();
    bit          ed, np, nm, f;
    int          s;
    logic [2:0]  acc;
    if (!SIM_RST_n) begin
      model_reset();
      return;
    end
    ed   = PIPASW && !m_sw;
    m_sw = PIPASW;
    if (ed) m_edges++;
    s     = m_slot();
    m_stb = ed && (s == 0);
    for (int a = 0; a < 3; a++) begin
      acc = (a == 0) ? ACCEL_X : (a == 1) ? ACCEL_Y : ACCEL_Z;
      f   = (a == 0) ? FAIL_X  : (a == 1) ? FAIL_Y  : FAIL_Z;
      np  = EN && PIPDAT && ((s <  m_P[a]) || f);
      nm  = EN && PIPDAT && ((s >= m_P[a]) || f);
      if (CNT_CLR)                     m_net[a] = '0;
      else if (np && !m_p[a] && !nm)   m_net[a] = m_net[a] + 16'd1;
      else if (nm && !m_m[a] && !np)   m_net[a] = m_net[a] - 16'd1;
      m_p[a] = np;
      m_m[a] = nm;
      if (m_stb || !EN) m_P[a] = 3 + offset_of(acc);
    end
  endtask

  // One clock: inputs already set at the falling edge; model and compare after the rise.
  task automatic tick();
    @(posedge SIM_CLK);
    model_step();
    #1;
    check("pipa", 32'({PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm}),
          32'({m_p[0], m_m[0], m_p[1], m_m[1], m_p[2], m_m[2]}));
    check("slot",  32'(SLOT),      32'(m_slot()));
    check("stb",   32'(FRAME_STB), 32'(m_stb));
    check("net_x", 32'(NET_X),     32'(m_net[0]));
    check("net_y", 32'(NET_Y),     32'(m_net[1]));
    check("net_z", 32'(NET_Z),     32'(m_net[2]));
    if (FRAME_STB) stb_cnt++;
    if (PIPAXp && !prev_xp) xp_rise++;
    if (PIPAXm && !prev_xm) xm_rise++;
    prev_xp = PIPAXp;
    prev_xm = PIPAXm;
    @(negedge SIM_CLK);
  endtask

  // One PIPASW edge followed by one PIPDAT pulse inside the new slot.
  task automatic step_slot();
    PIPASW = 1'b1; PIPDAT = 1'b0; tick();
    PIPASW = 1'b0; PIPDAT = 1'b1; tick();
    PIPDAT = 1'b0; tick();
  endtask

  task automatic advance_to(input int target);
    for (int k = 0; k < FRAME_LEN && m_slot() != target; k++)
      step_slot();
  endtask

  // Net change per axis over one complete frame that starts at a wrap.
  task automatic run_frame(output int dx, output int dy, output int dz);
    int bx, by, bz;
    advance_to(FRAME_LEN - 1);
    bx = int'($signed(NET_X)); by = int'($signed(NET_Y)); bz = int'($signed(NET_Z));
    repeat (FRAME_LEN) step_slot();
    dx = int'($signed(NET_X)) - bx;
    dy = int'($signed(NET_Y)) - by;
    dz = int'($signed(NET_Z)) - bz;
  endtask

  initial begin
    int dx, dy, dz, nz;
    SIM_RST_n = 1'b0; PIPASW = 1'b0; PIPDAT = 1'b0; EN = 1'b1;
    ACCEL_X = '0; ACCEL_Y = '0; ACCEL_Z = '0;
    FAIL_X = 1'b0; FAIL_Y = 1'b0; FAIL_Z = 1'b0; CNT_CLR = 1'b0;
    model_reset();
    @(negedge SIM_CLK);
    tick(); tick();
    check("rst_slot", 32'(SLOT), 32'd0);
    check("rst_netx", 32'(NET_X), 32'd0);
    SIM_RST_n = 1'b1;

    // Zero offset: two frames of 3-3 moding
    stb_cnt = 0; xp_rise = 0; xm_rise = 0;
    repeat (12) step_slot();
    check("f0_stb",  32'(stb_cnt), 32'd2);
    check("f0_xp",   32'(xp_rise), 32'd6);
    check("f0_xm",   32'(xm_rise), 32'd6);
    check("f0_netx", 32'(NET_X),   32'd0);

    // +1 on X written mid-frame, takes effect from the next frame
    advance_to(2);
    ACCEL_X = 3'd1;
    run_frame(dx, dy, dz);
    check("x_plus1_dx", 32'(dx), 32'd2);
    check("x_plus1_dy", 32'(dy), 32'd0);

    // Full negative on Y, -4 code on Z
    ACCEL_X = 3'd0; ACCEL_Y = 3'b101; ACCEL_Z = 3'b100;
    run_frame(dx, dy, dz);
    check("neg_dx", 32'(dx), 32'd0);
    check("neg_dy", 32'(dy), 32'(-6));
    check("neg_dz", 32'(dz), 32'(-6));

    // Fault inject on Z
    ACCEL_Y = 3'd0; ACCEL_Z = 3'd0;
    EN = 1'b0; tick(); EN = 1'b1;
    FAIL_Z = 1'b1;
    PIPASW = 1'b1; tick();
    nz = int'($signed(NET_Z));
    PIPASW = 1'b0; PIPDAT = 1'b1; tick();
    check("fail_zp", 32'(PIPAZp), 32'd1);
    check("fail_zm", 32'(PIPAZm), 32'd1);
    PIPDAT = 1'b0; tick();
    check("fail_netz", 32'(int'($signed(NET_Z))), 32'(nz));
    FAIL_Z = 1'b0;
    repeat (FRAME_LEN) step_slot();

    // X tally wrap at +32767 -> -32768
    ACCEL_X = 3'd3;
    EN = 1'b0; tick(); EN = 1'b1;
    CNT_CLR = 1'b1; tick(); CNT_CLR = 1'b0;
    check("clr_netx", 32'(NET_X), 32'd0);
    for (int i = 0; i < 32767; i++) begin
      PIPASW = 1'b1; PIPDAT = 1'b1; tick();
      PIPASW = 1'b0; PIPDAT = 1'b0; tick();
    end
    check("max_netx", 32'(NET_X), 32'h7fff);
    PIPASW = 1'b1; PIPDAT = 1'b1; tick();
    PIPASW = 1'b0; PIPDAT = 1'b0; tick();
    check("wrap_netx", 32'(NET_X), 32'h8000);
    PIPASW = 1'b1; PIPDAT = 1'b1; CNT_CLR = 1'b1; tick();
    check("clr_edge_netx", 32'(NET_X), 32'd0);
    CNT_CLR = 1'b0; PIPASW = 1'b0; PIPDAT = 1'b0; tick();

    // Reset mid-frame at slot 4 with PIPDAT high
    ACCEL_X = 3'd0;
    EN = 1'b0; tick(); EN = 1'b1;
    advance_to(3);
    PIPASW = 1'b1; PIPDAT = 1'b1; tick();
    check("pre_rst_slot", 32'(SLOT), 32'd4);
    PIPASW = 1'b0; SIM_RST_n = 1'b0; tick();
    check("rst_pipa", 32'({PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm}), 32'd0);
    check("rst_slot0", 32'(SLOT), 32'd0);
    SIM_RST_n = 1'b1; PIPDAT = 1'b0; tick();
    PIPASW = 1'b1; PIPDAT = 1'b1; tick();
    check("post_rst_slot", 32'(SLOT), 32'd1);
    check("post_rst_xp",   32'(PIPAXp), 32'd1);
    PIPASW = 1'b0; PIPDAT = 1'b0; tick();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      PIPASW    = 1'($urandom_range(0, 1));
      PIPDAT    = 1'($urandom_range(0, 1));
      EN        = ($urandom_range(0, 15) != 0);
      CNT_CLR   = ($urandom_range(0, 63) == 0);
      SIM_RST_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 31) == 0) begin
        ACCEL_X = 3'($urandom); ACCEL_Y = 3'($urandom); ACCEL_Z = 3'($urandom);
      end
      FAIL_X = ($urandom_range(0, 19) == 0);
      FAIL_Y = ($urandom_range(0, 19) == 0);
      FAIL_Z = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
